// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   state_t  : IDLE / BUSY access FSM state
//   BE_WORD  : byte enables for a full-word access
//   BE_BYTE0 : byte enable for byte lane 0; shifted by the address offset
package mem_stage_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the memory-access stage and data memory.
//   master : the stage (drives request, address, data, enables)
//   slave  : the memory (drives read data and ack)
interface mem_access_stage_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic [31:0] dmemRdata;
  logic        dmemAck;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemRdata, dmemAck
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemRdata, dmemAck
  );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks the addressed byte of a memory word and
// sign-extends it for byte loads; word loads pass through.
//   rdata_i  : word returned by data memory
//   offset_i : byte offset within the word (address bits [1:0])
//   byte_i   : 1 = byte load, 0 = word load
//   data_o   : aligned load value
module mem_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic        byte_i,
  output logic [31:0] data_o
);
  logic [7:0] sel;

  // Little-endian: offset 0 is bits [7:0].
  always_comb begin
    sel = rdata_i[7:0];
    case (offset_i)
      2'd0: sel = rdata_i[7:0];
      2'd1: sel = rdata_i[15:8];
      2'd2: sel = rdata_i[23:16];
      2'd3: sel = rdata_i[31:24];
      default: sel = rdata_i[7:0];
    endcase
    data_o = byte_i ? {{24{sel[7]}}, sel} : rdata_i;
  end
endmodule

// File: rtl/register32Bit.sv
// 32-bit register with synchronous active-high reset and load enable.
//   clk, reset : clock / synchronous reset (clears q)
//   en, d      : load q with d on the rising edge when en is high
//   q          : registered value
module register32Bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= 32'h0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Non-memory instructions pass the ALU result
// straight to MEM/WB; loads/stores go IDLE -> BUSY and wait on a
// variable-latency req/ack data memory, stalling upstream meanwhile.
//   clk, reset         : clock, synchronous active-high reset
//   memAddr, storedRt2 : effective address / ALU result, store data
//   memRead, memWrite  : load / store
//   memByte            : byte (1) or word (0) access
//   regWriteIn, writeRegIn : destination write enable / index
//   stall              : upstream hold request (combinational)
//   dmem               : data-memory bus (master side)
//   wbData, wbReg, wbRegWrite : registered MEM/WB result
//   memErr             : one-cycle pulse on invalid or timed-out access
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           memAddr,
  input  logic [31:0]           storedRt2,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memByte,
  input  logic                  regWriteIn,
  input  logic [REG_ADDR_W-1:0] writeRegIn,
  output logic                  stall,
  mem_access_stage_if.master    dmem,
  output logic [31:0]           wbData,
  output logic [REG_ADDR_W-1:0] wbReg,
  output logic                  wbRegWrite,
  output logic                  memErr
);
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic [31:0]             addr_q, data_q;
  logic                    byte_q, we_q, regw_q;
  logic [REG_ADDR_W-1:0]   reg_q;
  logic [REG_ADDR_W-1:0]   wb_reg_q;
  logic                    wb_regw_q, err_q;

  logic        is_mem, invalid, busy, at_limit;
  logic [31:0] load_val, wb_data_d;
  logic        wb_data_en;

  assign is_mem   = memRead | memWrite;
  // Read+write together is meaningless; word accesses must be aligned.
  assign invalid  = (memRead & memWrite) | (is_mem & ~memByte & (|memAddr[1:0]));
  assign busy     = (state_q == BUSY);
  assign at_limit = (cnt_q == MAX_W);

  // Stall while launching or waiting; released in the ack or timeout cycle
  // so upstream advances on the same edge the FSM returns to IDLE.
  assign stall = ~reset & ((~busy & is_mem & ~invalid) |
                           (busy & ~dmem.dmemAck & ~at_limit));

  // Bus outputs come from latched state only; idle bus reads as all zero.
  assign dmem.dmemReq   = busy;
  assign dmem.dmemWe    = busy & we_q;
  assign dmem.dmemAddr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem.dmemBe    = ~busy ? 4'h0 : (byte_q ? (BE_BYTE0 << addr_q[1:0]) : BE_WORD);
  assign dmem.dmemWdata = ~busy ? 32'h0 : (byte_q ? {4{data_q[7:0]}} : data_q);

  mem_load_align u_align (
    .rdata_i  (dmem.dmemRdata),
    .offset_i (addr_q[1:0]),
    .byte_i   (byte_q),
    .data_o   (load_val)
  );

  // wbData updates on pass-through or on a load's ack; otherwise it holds.
  assign wb_data_en = (~busy & ~is_mem) | (busy & dmem.dmemAck & ~we_q);
  assign wb_data_d  = busy ? load_val : memAddr;

  register32Bit u_wbdata (
    .clk   (clk),
    .reset (reset),
    .en    (wb_data_en),
    .d     (wb_data_d),
    .q     (wbData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      byte_q    <= 1'b0;
      we_q      <= 1'b0;
      regw_q    <= 1'b0;
      reg_q     <= '0;
      wb_reg_q  <= '0;
      wb_regw_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      wb_regw_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!is_mem) begin
            wb_reg_q  <= writeRegIn;
            wb_regw_q <= regWriteIn;
          end else if (invalid) begin
            err_q <= 1'b1;
          end else begin
            state_q <= BUSY;
            cnt_q   <= 8'd0;
            addr_q  <= memAddr;
            data_q  <= storedRt2;
            byte_q  <= memByte;
            we_q    <= memWrite;
            regw_q  <= regWriteIn;
            reg_q   <= writeRegIn;
          end
        end
        BUSY: begin
          if (dmem.dmemAck) begin
            state_q   <= IDLE;
            wb_reg_q  <= reg_q;
            wb_regw_q <= regw_q & ~we_q;
          end else if (at_limit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbReg      = wb_reg_q;
  assign wbRegWrite = wb_regw_q;
  assign memErr     = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddr, storedRt2;
  logic        memRead, memWrite, memByte, regWriteIn;
  logic [4:0]  writeRegIn;
  logic        stall;
  logic [31:0] wbData;
  logic [4:0]  wbReg;
  logic        wbRegWrite, memErr;

  int errors = 0;
  int checks = 0;

  mem_access_stage_if dmem_if ();

  mem_access_stage #(.REG_ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memAddr    (memAddr),
    .storedRt2  (storedRt2),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memByte    (memByte),
    .regWriteIn (regWriteIn),
    .writeRegIn (writeRegIn),
    .stall      (stall),
    .dmem       (dmem_if),
    .wbData     (wbData),
    .wbReg      (wbReg),
    .wbRegWrite (wbRegWrite),
    .memErr     (memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic push(input logic [31:0] d, input logic [4:0] r, input logic er);
    exp_t x;
    x.data = d; x.rg = r; x.err = er;
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write-back or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (wbRegWrite || memErr)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: wbRegWrite=%0b memErr=%0b wbData=%h, expected no output",
                 wbRegWrite, memErr, wbData);
      end else begin
        e = sb.pop_front();
        if (e.err) begin
          if (!(memErr && !wbRegWrite)) begin
            errors++;
            $display("FAIL err_pulse: memErr=%0b wbRegWrite=%0b expected memErr=1 wbRegWrite=0",
                     memErr, wbRegWrite);
          end
        end else if (!(wbRegWrite && !memErr && wbData === e.data && wbReg === e.rg)) begin
          errors++;
          $display("FAIL writeback: data=%h reg=%0d we=%0b err=%0b expected data=%h reg=%0d we=1 err=0",
                   wbData, wbReg, wbRegWrite, memErr, e.data, e.rg);
        end
      end
    end
  end

  task automatic nop();
    memAddr = 32'h0; storedRt2 = 32'h0; memRead = 1'b0; memWrite = 1'b0;
    memByte = 1'b0; regWriteIn = 1'b0; writeRegIn = 5'd0;
  endtask

  // Issue one instruction and play the memory: ack after ack_after BUSY
  // cycles without ack (-1 = never). Bus outputs are checked every BUSY cycle.
  task automatic access(input string name, input logic rd, input logic wr, input logic bt,
                        input logic [31:0] addr, input logic [31:0] data, input logic rw,
                        input logic [4:0] rg, input int ack_after, input logic [31:0] rdata,
                        input logic [3:0] ebe, input logic [31:0] ewdata,
                        input int exp_stall, input int exp_req);
    int sc, rc;
    logic done;
    memAddr = addr; storedRt2 = data; memRead = rd; memWrite = wr;
    memByte = bt; regWriteIn = rw; writeRegIn = rg;
    sc = 0; rc = 0;
    for (int c = 0; c < 40; c++) begin
      dmem_if.dmemAck   = dmem_if.dmemReq && (rc == ack_after);
      dmem_if.dmemRdata = dmem_if.dmemAck ? rdata : 32'h0;
      @(negedge clk);
      if (stall) sc++;
      done = !stall;
      if (dmem_if.dmemReq) begin
        rc++;
        chk({name, "_addr"}, dmem_if.dmemAddr, {addr[31:2], 2'b00});
        chk({name, "_be"}, {28'h0, dmem_if.dmemBe}, {28'h0, ebe});
        chk({name, "_we"}, {31'h0, dmem_if.dmemWe}, {31'h0, wr});
        if (wr) chk({name, "_wdata"}, dmem_if.dmemWdata, ewdata);
      end
      @(posedge clk); #1;
      if (done) break;
    end
    dmem_if.dmemAck = 1'b0;
    dmem_if.dmemRdata = 32'h0;
    nop();
    chk({name, "_stall_cycles"}, sc, exp_stall);
    chk({name, "_req_cycles"}, rc, exp_req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    nop();
    dmem_if.dmemAck = 1'b0;
    dmem_if.dmemRdata = 32'h0;
    // A valid access presented during reset must not raise stall.
    memRead = 1'b1; memAddr = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall_forced", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    nop();
    @(negedge clk);
    chk("reset_wbData", wbData, 32'h0);
    chk("reset_wbReg", {27'h0, wbReg}, 32'h0);
    chk("reset_wbRegWrite", {31'h0, wbRegWrite}, 32'h0);
    chk("reset_memErr", {31'h0, memErr}, 32'h0);
    chk("reset_dmemReq", {31'h0, dmem_if.dmemReq}, 32'h0);
    chk("reset_dmemBe", {28'h0, dmem_if.dmemBe}, 32'h0);
    chk("reset_dmemAddr", dmem_if.dmemAddr, 32'h0);
    @(posedge clk); #1;

    push(32'h0000_1234, 5'd7, 1'b0);
    access("pass", 0, 0, 0, 32'h0000_1234, 32'h0, 1, 5'd7, 0, 32'h0, 4'h0, 32'h0, 0, 0);

    push(32'hDEAD_BEEF, 5'd3, 1'b0);
    access("lw", 1, 0, 0, 32'h0000_0100, 32'h0, 1, 5'd3, 3, 32'hDEAD_BEEF, 4'hF, 32'h0, 4, 4);

    push(32'hFFFF_FF80, 5'd9, 1'b0);
    access("lb_neg", 1, 0, 1, 32'h0000_0103, 32'h0, 1, 5'd9, 1, 32'h8012_3456, 4'b1000, 32'h0, 2, 2);

    push(32'h0000_007F, 5'd10, 1'b0);
    access("lb_pos", 1, 0, 1, 32'h0000_0101, 32'h0, 1, 5'd10, 0, 32'h1234_7F56, 4'b0010, 32'h0, 1, 1);

    access("sb", 0, 1, 1, 32'h0000_0102, 32'h0000_00AB, 1, 5'd4, 0, 32'h0, 4'b0100, 32'hABAB_ABAB, 1, 1);

    access("sw", 0, 1, 0, 32'h0000_0200, 32'hCAFE_F00D, 0, 5'd0, 2, 32'h0, 4'hF, 32'hCAFE_F00D, 3, 3);

    push(32'h0, 5'd0, 1'b1);
    access("misalign", 1, 0, 0, 32'h0000_0102, 32'h0, 1, 5'd6, 0, 32'h0, 4'h0, 32'h0, 0, 0);

    push(32'h0, 5'd0, 1'b1);
    access("rd_and_wr", 1, 1, 0, 32'h0000_0100, 32'h0, 1, 5'd6, 0, 32'h0, 4'h0, 32'h0, 0, 0);

    push(32'h0, 5'd0, 1'b1);
    access("timeout", 1, 0, 0, 32'h0000_0104, 32'h0, 1, 5'd8, -1, 32'h0, 4'hF, 32'h0, 5, 5);

    push(32'hA5A5_0000, 5'd31, 1'b0);
    access("pass2", 0, 0, 0, 32'hA5A5_0000, 32'h0, 1, 5'd31, 0, 32'h0, 4'h0, 32'h0, 0, 0);

    // Reset while BUSY, then a late ack that must be ignored.
    memAddr = 32'h300; memRead = 1'b1; regWriteIn = 1'b1; writeRegIn = 5'd5;
    @(posedge clk); #1;
    chk("rstbusy_req_before", {31'h0, dmem_if.dmemReq}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstbusy_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    nop();
    dmem_if.dmemAck = 1'b1;
    dmem_if.dmemRdata = 32'h1111_1111;
    @(negedge clk);
    chk("rstbusy_req", {31'h0, dmem_if.dmemReq}, 32'h0);
    chk("rstbusy_we", {31'h0, dmem_if.dmemWe}, 32'h0);
    chk("rstbusy_be", {28'h0, dmem_if.dmemBe}, 32'h0);
    chk("rstbusy_addr", dmem_if.dmemAddr, 32'h0);
    chk("rstbusy_wdata", dmem_if.dmemWdata, 32'h0);
    chk("rstbusy_wbData", wbData, 32'h0);
    chk("rstbusy_wbReg", {27'h0, wbReg}, 32'h0);
    chk("rstbusy_wbRegWrite", {31'h0, wbRegWrite}, 32'h0);
    chk("rstbusy_memErr", {31'h0, memErr}, 32'h0);
    @(posedge clk); #1;
    dmem_if.dmemAck = 1'b0;
    dmem_if.dmemRdata = 32'h0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage directly downstream of the execute stage. It consumes the registered ALU result (`memAddr`) and forwarded store operand (`storedRt2`), and performs word or byte loads and stores against a variable-latency data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding. It presents a registered MEM/WB result to write-back.

## Interface
Parameters:
- `REG_ADDR_W`, 5: destination register index width.
- `MAX_WAIT`, 255: maximum cycles spent waiting for `dmemAck` before the access is aborted; legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `memAddr` input 32: effective address from execute, or ALU result for non-memory instructions.
- `storedRt2` input 32: store data.
- `memRead` input 1: load instruction.
- `memWrite` input 1: store instruction.
- `memByte` input 1: 1 = byte access (LB/SB), 0 = word access.
- `regWriteIn` input 1: instruction writes a register.
- `writeRegIn` input REG_ADDR_W: destination register.
- `stall` output 1: upstream must hold all inputs stable while high.
- `dmemReq` output 1: memory request valid.
- `dmemWe` output 1: 1 = write.
- `dmemAddr` output 32: word-aligned address.
- `dmemWdata` output 32: write data.
- `dmemBe` output 4: byte enables.
- `dmemRdata` input 32: read data; valid in the cycle `dmemAck` is high.
- `dmemAck` input 1: access complete.
- `wbData` output 32: result to write-back.
- `wbReg` output REG_ADDR_W: destination register to write-back.
- `wbRegWrite` output 1: write-back enable.
- `memErr` output 1: one-cycle pulse on a misaligned, invalid, or timed-out access.

## Operation
- FSM states are IDLE and BUSY.
- **IDLE, no access** (`memRead`=`memWrite`=0): pass-through. The next edge loads `wbData`=`memAddr`, `wbReg`=`writeRegIn`, `wbRegWrite`=`regWriteIn`.
- **IDLE, invalid access**: the access is invalid when `memRead`&&`memWrite`, or when it is a word access with `memAddr[1:0]`≠0.
  - No request is issued; the FSM stays in IDLE.
  - Next edge: `memErr`=1 and `wbRegWrite`=0.
- **IDLE, valid access**: `stall`=1 combinationally.
  - Next edge latches address, data, byte, read/write and destination into internal registers.
  - The FSM enters BUSY, the wait counter clears to 0, and `wbRegWrite` is loaded 0 (bubble).
- **BUSY outputs**: `dmemReq`=1, driven from the state register.
  - `dmemWe`=latched write flag.
  - `dmemAddr`={addr[31:2],2'b00}.
  - `dmemBe`: byte access = 4'b0001<<addr[1:0]; word access = 4'hF.
  - `dmemWdata`: byte store = {4{data[7:0]}}; word store = data.
- **BUSY with `dmemAck`=1**: `stall`=0 in that cycle; on the edge the FSM returns to IDLE.
  - Load: `wbData` = `dmemRdata`; a byte load selects byte addr[1:0] and sign-extends it.
  - Store: `wbRegWrite`=0.
  - `wbReg` is loaded from the latched destination, and `wbRegWrite` from the latched `regWriteIn` (load only).
- **BUSY without ack**: `stall`=1, the counter increments, and `wbRegWrite`=0.
- **BUSY timeout**: when the counter reaches MAX_WAIT without an ack, the FSM returns to IDLE at the next edge.
  - `dmemReq` drops, `memErr` pulses, `wbRegWrite`=0, and `stall`=0 that cycle.
  - An ack arriving after the timeout is ignored.
- An ack in IDLE is ignored.
- Back-to-back accesses: each access occupies IDLE→BUSY again, so there is no request overlap.

## Timing
- Reset values: state IDLE, counter 0, `wbData`=0, `wbReg`=0, `wbRegWrite`=0, `memErr`=0, `dmemReq`=0, `dmemWe`=0, `dmemBe`=0, `dmemAddr`=0, `dmemWdata`=0. `stall` is forced 0 while `reset`=1.
- Reset in BUSY aborts the access. `dmemReq` is 0 the cycle after the reset edge; no `memErr` and no write-back occur.
- Latency:
  - Non-memory instruction: 1 cycle to `wbData`.
  - Memory access: 1 + N cycles, where N≥1 is the number of BUSY cycles up to and including the ack.
- Minimum access: request cycle 1, ack in cycle 1, write-back visible in cycle 2.
- `stall` is combinational from state, inputs and `dmemAck`. `dmemReq` and `dmemWe` are registered-state driven.

## Structure
- Shared package `mem_stage_pkg` holds:
  - `typedef enum logic {IDLE, BUSY}` state type.
  - `BE_WORD`=4'hF and `BE_BYTE0`=4'b0001 constants.
- Sub-module `mem_load_align` (combinational): inputs rdata, offset[1:0], byte; outputs the aligned, sign-extended 32-bit load value.
- MEM/WB data register reuses the codebase's existing `register32Bit`.

## Test plan
- Pass-through: `memAddr`=0x0000_1234, `regWriteIn`=1, `writeRegIn`=7 → next cycle `wbData`=0x1234, `wbReg`=7, `wbRegWrite`=1; `stall` never high.
- Word load, ack after 3 BUSY cycles:
  - Stimulus: `memAddr`=0x100, `dmemRdata`=0xDEAD_BEEF.
  - `stall` is high for 4 cycles; `dmemAddr`=0x100 and `dmemBe`=0xF.
  - Result: `wbData`=0xDEADBEEF, `wbRegWrite`=1.
- Byte load and store:
  - LB at 0x103 with `dmemRdata`=0x80xx_xxxx → `wbData`=0xFFFF_FF80.
  - SB at 0x102 with `storedRt2`=0xAB → `dmemBe`=4'b0100, `dmemWdata`=0xABAB_ABAB, `dmemWe`=1, `wbRegWrite`=0.
- Misaligned word access at 0x102 → no `dmemReq`, `memErr` 1-cycle pulse, `wbRegWrite`=0, `stall`=0.
- Timeout with MAX_WAIT=4 and no ack → `dmemReq` high for 5 cycles (counter 0..4) then low, `memErr` pulse, `stall` released.
- Reset asserted mid-BUSY → next cycle `dmemReq`=0 and all outputs at reset values; a late `dmemAck` produces no write-back.
